// File: rtl/ps2_gamepad_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_gamepad_decoder_if
// Description : Byte handshake between the PS/2 receiver (producer) and
//               the gamepad decoder (consumer).
//                 data         8  scan-code byte
//                 data_valid   1  data holds a byte to transfer
//                 buffer_ready 1  consumer can take a byte this edge
//               master = receiver side, slave = decoder side.
// Revision    : 1.0  initial release
// ============================================================================
interface ps2_gamepad_decoder_if;
  logic [7:0] data;
  logic       data_valid;
  logic       buffer_ready;

  modport master (
    output data,
    output data_valid,
    input  buffer_ready
  );

  modport slave (
    input  data,
    input  data_valid,
    output buffer_ready
  );
endinterface
`default_nettype wire

// File: rtl/ps2_gamepad_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_gamepad_decoder
// Description : Turns a stream of PS/2 set-2 scan codes into the live NES
//               pad state (A, B, SELECT, START, UP, DOWN, LEFT, RIGHT).
//               Handles E0 (extended), F0 (break), E1 (pause) prefixes,
//               BAT (AA/FC) re-plug and 00/FF overrun bytes.
// Ports       : clk_i        in   system clock
//               rst_n_i      in   asynchronous active-low reset
//               bus          slv  byte handshake (data/data_valid/buffer_ready)
//               buttons_o    out  pressed=1 [0]A [1]B [2]SEL [3]START
//                                 [4]UP [5]DOWN [6]LEFT [7]RIGHT
//               key_event_o  out  1-cycle pulse when buttons_o changes
// Parameters  : TIMEOUT_CYCLES  cycles allowed between bytes of a sequence
// Config      : PS2_PAD_SOCD_CLEAN_EN  when defined, opposing directions
//               held together both read as released
// Revision    : 1.0  initial release
// ============================================================================
module ps2_gamepad_decoder #(
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  wire logic             clk_i,
  input  wire logic             rst_n_i,
  ps2_gamepad_decoder_if.slave  bus,
  output logic [7:0]            buttons_o,
  output logic                  key_event_o
);

  localparam int c_timer_w = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_timer_w-1:0] c_timeout_last = c_timer_w'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_ext     = 3'd1;
  localparam logic [2:0] c_brk     = 3'd2;
  localparam logic [2:0] c_ext_brk = 3'd3;
  localparam logic [2:0] c_pause   = 3'd4;

  // Pause sequence is E1 followed by seven more bytes.
  localparam logic [2:0] c_pause_len = 3'd7;

  logic [2:0]           r_state;
  logic [2:0]           w_state_next;
  logic                 r_ready;
  logic                 r_decode;
  logic [7:0]           r_byte;
  logic [7:0]           r_base;
  logic [7:0]           r_ext;
  logic [7:0]           w_base_next;
  logic [7:0]           w_ext_next;
  logic [2:0]           r_pause_cnt;
  logic [2:0]           w_pause_cnt_next;
  logic [c_timer_w-1:0] r_timer;
  logic                 w_accept;
  logic                 w_timeout;
  logic                 w_overrun;
  logic                 w_fake_shift;
  logic [7:0]           w_pad;
  logic [7:0]           w_pad_filt;
  logic [7:0]           r_buttons;
  logic                 r_key_event;

  // Single-byte codes that also drive the pad (Q, W, SPACE, ENTER, numpad).
  function automatic logic [7:0] f_base_mask(input logic [7:0] code);
    case (code)
      8'h15:   f_base_mask = 8'h01;
      8'h1D:   f_base_mask = 8'h02;
      8'h29:   f_base_mask = 8'h04;
      8'h5A:   f_base_mask = 8'h08;
      8'h75:   f_base_mask = 8'h10;
      8'h72:   f_base_mask = 8'h20;
      8'h6B:   f_base_mask = 8'h40;
      8'h74:   f_base_mask = 8'h80;
      default: f_base_mask = 8'h00;
    endcase
  endfunction

  // E0-prefixed codes (keypad ENTER, cursor arrows).
  function automatic logic [7:0] f_ext_mask(input logic [7:0] code);
    case (code)
      8'h5A:   f_ext_mask = 8'h08;
      8'h75:   f_ext_mask = 8'h10;
      8'h72:   f_ext_mask = 8'h20;
      8'h6B:   f_ext_mask = 8'h40;
      8'h74:   f_ext_mask = 8'h80;
      default: f_ext_mask = 8'h00;
    endcase
  endfunction

  assign w_accept     = bus.data_valid & r_ready;
  assign w_overrun    = (r_byte == 8'h00) || (r_byte == 8'hFF);
  assign w_fake_shift = (r_byte == 8'h12) || (r_byte == 8'h59);
  // Not checked during a decode cycle so a byte in flight always wins.
  assign w_timeout    = (r_state != c_idle) && !r_decode && (r_timer == c_timeout_last);

  assign bus.buffer_ready = r_ready;

  // Handshake: ready drops for exactly the decode cycle after each accept.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ready  <= 1'b0;
      r_decode <= 1'b0;
      r_byte   <= 8'h00;
    end else begin
      r_ready  <= !w_accept;
      r_decode <= w_accept;
      if (w_accept) begin
        r_byte <= bus.data;
      end
    end
  end

  // Inter-byte timer, saturating.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_timer <= '0;
    end else if (w_accept) begin
      r_timer <= '0;
    end else if ((r_state != c_idle) && (r_timer != '1)) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    if (r_decode) begin
      if (w_overrun) begin
        w_state_next = c_idle;
      end else begin
        case (r_state)
          c_idle: begin
            if (r_byte == 8'hE0)      w_state_next = c_ext;
            else if (r_byte == 8'hF0) w_state_next = c_brk;
            else if (r_byte == 8'hE1) w_state_next = c_pause;
            else                      w_state_next = c_idle;
          end
          c_ext:     w_state_next = (r_byte == 8'hF0) ? c_ext_brk : c_idle;
          c_brk:     w_state_next = c_idle;
          c_ext_brk: w_state_next = c_idle;
          c_pause:   w_state_next = (r_pause_cnt <= 3'd1) ? c_idle : c_pause;
          default:   w_state_next = c_idle;
        endcase
      end
    end else if (w_timeout) begin
      w_state_next = c_idle;
    end
  end

  // FSM: key-state and pause-counter updates
  always_comb begin
    w_base_next      = r_base;
    w_ext_next       = r_ext;
    w_pause_cnt_next = r_pause_cnt;
    if (r_decode && !w_overrun) begin
      case (r_state)
        c_idle: begin
          if (r_byte == 8'hE1) begin
            w_pause_cnt_next = c_pause_len;
          end else if ((r_byte == 8'hAA) || (r_byte == 8'hFC)) begin
            // Keyboard re-plugged: nothing can still be held.
            w_base_next = 8'h00;
            w_ext_next  = 8'h00;
          end else if ((r_byte != 8'hE0) && (r_byte != 8'hF0)) begin
            w_base_next = r_base | f_base_mask(r_byte);
          end
        end
        c_ext: begin
          if ((r_byte != 8'hF0) && !w_fake_shift) begin
            w_ext_next = r_ext | f_ext_mask(r_byte);
          end
        end
        c_brk: begin
          w_base_next = r_base & ~f_base_mask(r_byte);
        end
        c_ext_brk: begin
          if (!w_fake_shift) begin
            w_ext_next = r_ext & ~f_ext_mask(r_byte);
          end
        end
        c_pause: begin
          if (r_pause_cnt != 3'd0) begin
            w_pause_cnt_next = r_pause_cnt - 3'd1;
          end
        end
        default: begin
          w_base_next = r_base;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_base      <= 8'h00;
      r_ext       <= 8'h00;
      r_pause_cnt <= 3'd0;
    end else begin
      r_base      <= w_base_next;
      r_ext       <= w_ext_next;
      r_pause_cnt <= w_pause_cnt_next;
    end
  end

  // Arrow and numpad sources are kept apart so releasing one does not
  // release a still-held twin.
  assign w_pad = r_base | r_ext;

`ifdef PS2_PAD_SOCD_CLEAN_EN
  always_comb begin
    w_pad_filt = w_pad;
    if (w_pad[4] && w_pad[5]) begin
      w_pad_filt[4] = 1'b0;
      w_pad_filt[5] = 1'b0;
    end
    if (w_pad[6] && w_pad[7]) begin
      w_pad_filt[6] = 1'b0;
      w_pad_filt[7] = 1'b0;
    end
  end
`else
  assign w_pad_filt = w_pad;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_buttons   <= 8'h00;
      r_key_event <= 1'b0;
    end else begin
      r_buttons   <= w_pad_filt;
      r_key_event <= (w_pad_filt != r_buttons);
    end
  end

  assign buttons_o   = r_buttons;
  assign key_event_o = r_key_event;

endmodule
`default_nettype wire

// File: tb/tb_ps2_gamepad_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_gamepad_decoder
// Description : Directed self-checking bench for ps2_gamepad_decoder.
//               Expected values are hand-derived from the key map.
//               Honours PS2_PAD_SOCD_CLEAN_EN when choosing the expected
//               value for opposing directions.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_gamepad_decoder;

  localparam int c_timeout = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] buttons;
  logic       key_event;

  int n_pass  = 0;
  int n_total = 0;
  int ev_total = 0;
  int ev_base;

  ps2_gamepad_decoder_if bus ();

  ps2_gamepad_decoder #(
    .TIMEOUT_CYCLES (c_timeout)
  ) u_dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .bus         (bus.slave),
    .buttons_o   (buttons),
    .key_event_o (key_event)
  );

  always #5 clk = ~clk;

  // Count key_event pulses, one sample per cycle.
  always @(negedge clk) begin
    if (key_event) ev_total <= ev_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Present one byte and hold it until accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    bus.data       = b;
    bus.data_valid = 1'b1;
    n = 0;
    while (!bus.buffer_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.buffer_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
    #1;
  endtask

  logic [3:0] rdy_seq;
  logic [7:0] exp_socd;

  initial begin
    rst_n          = 1'b0;
    bus.data       = 8'h00;
    bus.data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus.buffer_ready}, 32'd0);
    check("rst_buttons", {24'd0, buttons}, 32'h00);
    check("rst_event", {31'd0, key_event}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, bus.buffer_ready}, 32'd1);

    // Press A: exact latency and one pulse.
    ev_base = ev_total;
    send_byte(8'h15);
    @(negedge clk);
    @(negedge clk);
    check("a_lat_early", {24'd0, buttons}, 32'h00);
    @(negedge clk);
    check("a_lat_buttons", {24'd0, buttons}, 32'h01);
    check("a_lat_event", {31'd0, key_event}, 32'd1);
    settle();
    check("a_ev_count", ev_total - ev_base, 32'd1);

    // Release A.
    ev_base = ev_total;
    send_byte(8'hF0); send_byte(8'h15); settle();
    check("a_rel", {24'd0, buttons}, 32'h00);
    check("a_rel_ev", ev_total - ev_base, 32'd1);

    // Arrow and numpad UP held independently.
    send_byte(8'hE0); send_byte(8'h75); send_byte(8'h75); settle();
    check("up_both", {24'd0, buttons}, 32'h10);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75); settle();
    check("up_arrow_rel", {24'd0, buttons}, 32'h10);
    send_byte(8'hF0); send_byte(8'h75); settle();
    check("up_numpad_rel", {24'd0, buttons}, 32'h00);

    // Fake shift ignored, extended RIGHT pressed.
    send_byte(8'hE0); send_byte(8'h12); send_byte(8'hE0); send_byte(8'h74); settle();
    check("fake_shift", {24'd0, buttons}, 32'h80);

    // Pause sequence: no key change, FSM back in IDLE (next make lands).
    ev_base = ev_total;
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77); settle();
    check("pause_hold", {24'd0, buttons}, 32'h80);
    check("pause_no_ev", ev_total - ev_base, 32'd0);
    send_byte(8'h15); settle();
    check("pause_idle", {24'd0, buttons}, 32'h81);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    send_byte(8'hF0); send_byte(8'h15); settle();
    check("clear_1", {24'd0, buttons}, 32'h00);

    // Timeout discards the E0 prefix; 72 lands on the numpad path.
    send_byte(8'hE0);
    repeat (c_timeout + 4) @(negedge clk);
    send_byte(8'h72); settle();
    check("timeout_make", {24'd0, buttons}, 32'h20);
    send_byte(8'hF0); send_byte(8'h72); settle();
    check("timeout_base_path", {24'd0, buttons}, 32'h00);

    // BAT clears everything.
    send_byte(8'h15); send_byte(8'h1D); send_byte(8'h29); send_byte(8'h5A); settle();
    check("abss", {24'd0, buttons}, 32'h0F);
    ev_base = ev_total;
    send_byte(8'hAA); settle();
    check("bat_clear", {24'd0, buttons}, 32'h00);
    check("bat_ev", ev_total - ev_base, 32'd1);

    // Back-to-back with data_valid held high.
    @(negedge clk);
    bus.data = 8'h15; bus.data_valid = 1'b1;
    rdy_seq[3] = bus.buffer_ready;
    @(posedge clk); #1;
    bus.data = 8'h1D;
    @(negedge clk); rdy_seq[2] = bus.buffer_ready;
    @(negedge clk); rdy_seq[1] = bus.buffer_ready;
    @(posedge clk); #1;
    @(negedge clk); rdy_seq[0] = bus.buffer_ready;
    bus.data_valid = 1'b0;
    settle();
    check("b2b_ready", {28'd0, rdy_seq}, 32'hA);
    check("b2b_buttons", {24'd0, buttons}, 32'h03);
    ev_base = ev_total;
    send_byte(8'h15); settle();
    check("typematic", {24'd0, buttons}, 32'h03);
    check("typematic_ev", ev_total - ev_base, 32'd0);

    // Opposing directions.
`ifdef PS2_PAD_SOCD_CLEAN_EN
    exp_socd = 8'h03;
`else
    exp_socd = 8'h33;
`endif
    send_byte(8'h75); send_byte(8'h72); settle();
    check("socd", {24'd0, buttons}, {24'd0, exp_socd});
    send_byte(8'hF0); send_byte(8'h75); send_byte(8'hF0); send_byte(8'h72); settle();
    check("socd_rel", {24'd0, buttons}, 32'h03);

    // Overrun inside EXT returns to IDLE, so F0 15 releases A.
    send_byte(8'hE0); send_byte(8'h00); send_byte(8'hF0); send_byte(8'h15); settle();
    check("overrun", {24'd0, buttons}, 32'h02);

    // Reset mid-sequence.
    send_byte(8'hE0); send_byte(8'hF0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_buttons", {24'd0, buttons}, 32'h00);
    check("midrst_ready", {31'd0, bus.buffer_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    send_byte(8'h75); settle();
    check("midrst_idle", {24'd0, buttons}, 32'h10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
